// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes instruction-fetch and load/store requests onto a
// single shared memory bus, one outstanding transaction at a time.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> round-robin between fetch and data port
//   undefined -> fixed priority, data port over fetch
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    icache_req,
    input  logic [ADDR_WIDTH-1:0]   icache_addr,
    output logic [DATA_WIDTH-1:0]   icache_data,
    output logic                    icache_valid,
    input  logic                    dcache_rreq,
    input  logic                    dcache_wreq,
    input  logic [ADDR_WIDTH-1:0]   dcache_addr,
    input  logic [DATA_WIDTH-1:0]   dcache_wdata,
    input  logic [DATA_WIDTH/8-1:0] dcache_byte_enable,
    output logic [DATA_WIDTH-1:0]   dcache_rdata,
    output logic                    dcache_rvalid,
    output logic                    dcache_wvalid,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e                  state_q, state_d;

    // Latched transaction fields; these drive the bus directly.
    logic                    req_q,    req_d;
    logic                    we_q,     we_d;
    logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic [BE_WIDTH-1:0]     be_q,     be_d;
    logic                    src_is_d_q, src_is_d_d;

    // Completion pulses and the shared read-data register.
    logic                    ivalid_q, ivalid_d;
    logic                    rvalid_q, rvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;

    logic                    i_pend_c;
    logic                    d_pend_c;
    logic                    any_pend_c;
    logic                    win_d_c;
    logic                    take_c;
    logic                    done_c;

    assign i_pend_c   = icache_req;
    assign d_pend_c   = dcache_rreq | dcache_wreq;
    assign any_pend_c = i_pend_c | d_pend_c;
    assign take_c     = (state_q == S_IDLE) && any_pend_c;
    assign done_c     = (state_q == S_WAIT) && mem_ack;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;

    // Round-robin winner: on a tie, the port that was not granted last wins.
    always_comb begin
        win_d_c = d_pend_c;
        if (i_pend_c && d_pend_c) begin
            win_d_c = ~last_d_q;
        end
    end

    // Last-grant tracking, refreshed every time a transaction is launched.
    always_comb begin
        last_d_d = last_d_q;
        if (take_c) begin
            last_d_d = win_d_c;
        end
    end

    // Last-grant register; resets to the fetch port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    // Fixed priority: any data-port request beats fetch.
    assign win_d_c = d_pend_c;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (any_pend_c) state_d = S_REQ;
            S_REQ:  if (mem_gnt)    state_d = S_WAIT;
            S_WAIT: if (mem_ack)    state_d = S_RESP;
            S_RESP:                 state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Output next values: latch winner fields in IDLE, capture read data on ack.
    always_comb begin
        req_d      = 1'b0;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        src_is_d_d = src_is_d_q;
        ivalid_d   = 1'b0;
        rvalid_d   = 1'b0;
        wvalid_d   = 1'b0;
        rdata_d    = rdata_q;

        if (take_c) begin
            src_is_d_d = win_d_c;
            if (win_d_c) begin
                // A simultaneous load and store is treated as a store.
                we_d    = dcache_wreq;
                addr_d  = dcache_addr;
                wdata_d = dcache_wreq ? dcache_wdata : {DATA_WIDTH{1'b0}};
                be_d    = dcache_wreq ? dcache_byte_enable : {BE_WIDTH{1'b1}};
            end else begin
                we_d    = 1'b0;
                addr_d  = icache_addr;
                wdata_d = {DATA_WIDTH{1'b0}};
                be_d    = {BE_WIDTH{1'b1}};
            end
        end

        req_d = (state_d == S_REQ);

        if (done_c) begin
            if (!we_q) begin
                rdata_d = mem_rdata;
            end
            ivalid_d = ~src_is_d_q;
            rvalid_d = src_is_d_q & ~we_q;
            wvalid_d = src_is_d_q & we_q;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            wdata_q    <= {DATA_WIDTH{1'b0}};
            be_q       <= {BE_WIDTH{1'b0}};
            src_is_d_q <= 1'b0;
            ivalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            wvalid_q   <= 1'b0;
            rdata_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            src_is_d_q <= src_is_d_d;
            ivalid_q   <= ivalid_d;
            rvalid_q   <= rvalid_d;
            wvalid_q   <= wvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_be        = be_q;
    assign icache_valid  = ivalid_q;
    assign dcache_rvalid = rvalid_q;
    assign dcache_wvalid = wvalid_q;
    assign icache_data   = rdata_q;
    assign dcache_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference model (winner choice, bus fields, pulses, data).
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_req;
    logic [AW-1:0] icache_addr;
    logic [DW-1:0] icache_data;
    logic          icache_valid;
    logic          dcache_rreq;
    logic          dcache_wreq;
    logic [AW-1:0] dcache_addr;
    logic [DW-1:0] dcache_wdata;
    logic [BW-1:0] dcache_byte_enable;
    logic [DW-1:0] dcache_rdata;
    logic          dcache_rvalid;
    logic          dcache_wvalid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_gnt;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Reference model state: which port was granted last, and the value the
    // shared read-data register should hold.
    logic          model_last_d;
    logic [DW-1:0] model_rdata;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk                (clk),
        .rst                (rst),
        .icache_req         (icache_req),
        .icache_addr        (icache_addr),
        .icache_data        (icache_data),
        .icache_valid       (icache_valid),
        .dcache_rreq        (dcache_rreq),
        .dcache_wreq        (dcache_wreq),
        .dcache_addr        (dcache_addr),
        .dcache_wdata       (dcache_wdata),
        .dcache_byte_enable (dcache_byte_enable),
        .dcache_rdata       (dcache_rdata),
        .dcache_rvalid      (dcache_rvalid),
        .dcache_wvalid      (dcache_wvalid),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_be             (mem_be),
        .mem_gnt            (mem_gnt),
        .mem_ack            (mem_ack),
        .mem_rdata          (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pulses(input string tag, input logic ei, input logic er, input logic ew);
        chk({tag, "_ivalid"}, icache_valid, ei);
        chk({tag, "_rvalid"}, dcache_rvalid, er);
        chk({tag, "_wvalid"}, dcache_wvalid, ew);
    endtask

    // Winner rule: 1 = data port wins.
    function automatic logic model_pick_d(input logic ireq, input logic dreq);
`ifdef ARB_ROUND_ROBIN_EN
        if (ireq && dreq) return !model_last_d;
`endif
        return dreq;
    endfunction

    // Runs one transaction from an IDLE cycle (called #1 after a rising edge
    // with the DUT idle and requests already driven). gd/ad are the numbers of
    // cycles gnt/ack are held low. Returns in the IDLE cycle after RESP.
    task automatic serve(input int gd, input int ad, input logic [DW-1:0] rd,
                         input bit drop, output int vcyc);
        logic          win_d;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [BW-1:0] e_be;
        logic [AW-1:0] sv_ia;
        logic [AW-1:0] sv_da;
        logic [DW-1:0] sv_wd;
        logic [BW-1:0] sv_be;

        vcyc  = -1;
        win_d = model_pick_d(icache_req, dcache_rreq | dcache_wreq);
        if (win_d) begin
            e_we    = dcache_wreq;
            e_addr  = dcache_addr;
            e_wdata = dcache_wdata;
            e_be    = dcache_wreq ? dcache_byte_enable : '1;
        end else begin
            e_we    = 1'b0;
            e_addr  = icache_addr;
            e_wdata = '0;
            e_be    = '1;
        end
        model_last_d = win_d;

        @(posedge clk); #1;
        chk("req_after_sample", mem_req, 1);
        if (mem_req !== 1'b1) return;

        // REQ: fields must hold while inputs wander and gnt is withheld.
        sv_ia = icache_addr;
        sv_da = dcache_addr;
        sv_wd = dcache_wdata;
        sv_be = dcache_byte_enable;
        for (int k = 0; k <= gd; k++) begin
            chk("req_held", mem_req, 1);
            chk("req_we", mem_we, e_we);
            chk("req_addr", mem_addr, e_addr);
            chk("req_be", mem_be, e_be);
            if (e_we) chk("req_wdata", mem_wdata, e_wdata);
            chk_pulses("req", 1'b0, 1'b0, 1'b0);
            mem_gnt            = (k == gd);
            mem_ack            = 1'($urandom_range(0, 1));
            mem_rdata          = DW'($urandom);
            icache_addr        = AW'($urandom);
            dcache_addr        = AW'($urandom);
            dcache_wdata       = DW'($urandom);
            dcache_byte_enable = BW'($urandom);
            @(posedge clk); #1;
        end
        mem_gnt            = 1'b0;
        icache_addr        = sv_ia;
        dcache_addr        = sv_da;
        dcache_wdata       = sv_wd;
        dcache_byte_enable = sv_be;

        // WAIT: bus request dropped, no completion until ack.
        for (int k = 0; k <= ad; k++) begin
            chk("wait_req_low", mem_req, 0);
            chk_pulses("wait", 1'b0, 1'b0, 1'b0);
            mem_ack   = (k == ad);
            mem_rdata = (k == ad) ? rd : DW'($urandom);
            @(posedge clk); #1;
        end
        mem_ack   = 1'b0;
        mem_rdata = DW'($urandom);

        // RESP: exactly one pulse, data register updated only by reads.
        if (!e_we) model_rdata = rd;
        chk_pulses("resp", !win_d, win_d && !e_we, win_d && e_we);
        chk("resp_icache_data", icache_data, model_rdata);
        chk("resp_dcache_rdata", dcache_rdata, model_rdata);
        vcyc = cyc;
        if (drop) begin
            if (win_d) begin
                dcache_rreq = 1'b0;
                dcache_wreq = 1'b0;
            end else begin
                icache_req = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk_pulses("after_resp", 1'b0, 1'b0, 1'b0);
        chk("after_resp_req", mem_req, 0);
        chk("after_resp_data", icache_data, model_rdata);
    endtask

    // Serve requests until none are pending, each with random wait states.
    task automatic drain();
        int v;
        for (int n = 0; n < 4; n++) begin
            if (icache_req || dcache_rreq || dcache_wreq)
                serve($urandom_range(0, 3), $urandom_range(0, 3), DW'($urandom), 1'b1, v);
        end
    endtask

    initial begin
        int v;
        int prev;

        rst                = 1'b1;
        icache_req         = 1'b0;
        icache_addr        = '0;
        dcache_rreq        = 1'b0;
        dcache_wreq        = 1'b0;
        dcache_addr        = '0;
        dcache_wdata       = '0;
        dcache_byte_enable = '0;
        mem_gnt            = 1'b0;
        mem_ack            = 1'b0;
        mem_rdata          = '0;
        model_last_d       = 1'b0;
        model_rdata        = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_rdata", icache_data, 0);
        chk_pulses("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single fetch, no wait states.
        icache_req  = 1'b1;
        icache_addr = 32'h0000_0040;
        serve(0, 0, 32'h0000_0013, 1'b1, v);
        chk("fetch_data", icache_data, 32'h0000_0013);

        // Store with gnt and ack wait states; read-data register untouched.
        dcache_wreq        = 1'b1;
        dcache_addr        = 32'h0000_0100;
        dcache_wdata       = 32'hDEAD_BEEF;
        dcache_byte_enable = 4'h3;
        serve(2, 3, 32'hCAFE_F00D, 1'b1, v);
        chk("store_keeps_rdata", dcache_rdata, 32'h0000_0013);

        // Simultaneous fetch and load: model decides order.
        icache_req   = 1'b1;
        icache_addr  = 32'h0000_0200;
        dcache_rreq  = 1'b1;
        dcache_addr  = 32'h0000_0300;
        drain();

        // Load and store together counts as a store.
        dcache_rreq        = 1'b1;
        dcache_wreq        = 1'b1;
        dcache_addr        = 32'h0000_0404;
        dcache_wdata       = 32'h1234_5678;
        dcache_byte_enable = 4'hC;
        serve(1, 0, 32'h5555_AAAA, 1'b1, v);

        // Reset asserted while in REQ: mem_req drops at once.
        icache_req  = 1'b1;
        icache_addr = 32'h0000_0080;
        @(posedge clk); #1;
        chk("pre_rst_req", mem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_in_req_mem_req", mem_req, 0);
        model_last_d = 1'b0;
        model_rdata  = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset asserted while in WAIT: no pulse, later ack ignored.
        @(posedge clk); #1;
        chk("rw_req", mem_req, 1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt    = 1'b0;
        icache_req = 1'b0;
        chk("rw_wait_req", mem_req, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_in_wait_mem_req", mem_req, 0);
        chk("rst_in_wait_addr", mem_addr, 0);
        chk("rst_in_wait_rdata", icache_data, 0);
        chk_pulses("rst_in_wait", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_pulses("stray_ack", 1'b0, 1'b0, 1'b0);
            chk("stray_ack_req", mem_req, 0);
            chk("stray_ack_data", icache_data, 0);
        end
        mem_ack = 1'b0;
        icache_req  = 1'b1;
        icache_addr = 32'h0000_0044;
        serve(1, 1, 32'h0BAD_C0DE, 1'b1, v);

        // Held fetch request: three back-to-back transactions.
        icache_req  = 1'b1;
        icache_addr = 32'h0000_0000;
        prev        = 0;
        for (int k = 0; k < 3; k++) begin
            serve(0, 0, 32'h0000_1000 + DW'(k), (k == 2), v);
            if (k > 0) chk("b2b_spacing", 64'(v - prev), 4);
            prev        = v;
            icache_addr = AW'(4 * (k + 1));
        end

        // Randomized mixes of requests.
        for (int it = 0; it < 30; it++) begin
            icache_req         = 1'($urandom_range(0, 1));
            dcache_rreq        = 1'($urandom_range(0, 1));
            dcache_wreq        = 1'($urandom_range(0, 1));
            if (!icache_req && !dcache_rreq && !dcache_wreq) icache_req = 1'b1;
            icache_addr        = AW'($urandom);
            dcache_addr        = AW'($urandom);
            dcache_wdata       = DW'($urandom);
            dcache_byte_enable = BW'($urandom);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
